// File: rtl/eq_pkg.sv
// Shared sizing and FSM encoding for the equalizer coefficient loader slice.
package eq_pkg;

   localparam int NUMBER_OF_FILTERS = 8;
   localparam int NUMBER_OF_TAPS    = 64;
   localparam int COEFF_BITS        = 16;
   localparam int HDR_IDX_BITS      = 3;

   typedef enum logic [2:0] {
      IDLE,
      HDR_OK,
      LOAD,
      WAIT_COMMIT,
      DRAIN
   } eq_state_t;

endpackage

// File: rtl/eq_coeff_loader_if.sv
// Byte-stream valid/ready channel carrying coefficient frames into the loader.
interface eq_coeff_loader_if;

   logic       s_valid;
   logic       s_ready;
   logic [7:0] s_data;
   logic       s_last;

   modport master (output s_valid, output s_data, output s_last, input s_ready);
   modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/eq_coeff_bank.sv
// Active coefficient bank: holds every filter and overwrites exactly one filter per commit.
module eq_coeff_bank #(
   parameter int NUMBER_OF_FILTERS = eq_pkg::NUMBER_OF_FILTERS,
   parameter int NUMBER_OF_TAPS    = eq_pkg::NUMBER_OF_TAPS,
   parameter int COEFF_BITS        = eq_pkg::COEFF_BITS
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  commit,
   input  logic [eq_pkg::HDR_IDX_BITS-1:0]                       commit_idx,
   input  logic [NUMBER_OF_TAPS*COEFF_BITS-1:0]                  commit_data,
   output logic [NUMBER_OF_FILTERS*NUMBER_OF_TAPS*COEFF_BITS-1:0] coeffs_feed
);

   localparam int IDX_BITS    = eq_pkg::HDR_IDX_BITS;
   localparam int FILTER_BITS = NUMBER_OF_TAPS * COEFF_BITS;

   // NOTE: the bank is plain flops, not RAM, so it can and must clear on reset;
   // a RAM-mapped array would be left unreset and initialised by writes instead.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         coeffs_feed <= '0;
      end else if (commit) begin
         for (int f = 0; f < NUMBER_OF_FILTERS; f++) begin
            if (commit_idx == IDX_BITS'(f)) begin
               coeffs_feed[f*FILTER_BITS +: FILTER_BITS] <= commit_data;
            end
         end
      end
   end

endmodule

// File: rtl/eq_coeff_loader.sv
// Parses header + coefficient byte frames into a shadow filter and commits it on phase_min.
// Optional trailing XOR checksum byte: define EQ_COEFF_LOADER_CHECKSUM_EN.
module eq_coeff_loader #(
   parameter int NUMBER_OF_FILTERS = eq_pkg::NUMBER_OF_FILTERS,
   parameter int NUMBER_OF_TAPS    = eq_pkg::NUMBER_OF_TAPS,
   parameter int COEFF_BITS        = eq_pkg::COEFF_BITS
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic                                                  clk_enable,
   input  logic                                                  phase_min,
   eq_coeff_loader_if.slave                                      s,
   output logic [NUMBER_OF_FILTERS*NUMBER_OF_TAPS*COEFF_BITS-1:0] coeffs_feed,
   output logic                                                  commit_done,
   output logic                                                  frame_error
);

   import eq_pkg::*;

   localparam int BYTES_PER_TAP = COEFF_BITS / 8;
   localparam int COEFF_BYTES   = NUMBER_OF_TAPS * BYTES_PER_TAP;
`ifdef EQ_COEFF_LOADER_CHECKSUM_EN
   localparam int DATA_BYTES    = COEFF_BYTES + 1;
`else
   localparam int DATA_BYTES    = COEFF_BYTES;
`endif
   localparam int CNT_BITS      = $clog2(DATA_BYTES + 1);
   localparam int SHADOW_BITS   = NUMBER_OF_TAPS * COEFF_BITS;

   eq_state_t                   state_q, state_d;
   logic [CNT_BITS-1:0]         cnt_q, cnt_d;
   logic [HDR_IDX_BITS-1:0]     idx_q, idx_d;
   logic [SHADOW_BITS-1:0]      shadow_q, shadow_d;
   logic [SHADOW_BITS-1:0]      commit_data;
   logic                        ready_en_q;
   logic                        accept;
   logic                        is_final;
   logic                        in_coeffs;
   logic                        csum_ok;
   logic                        commit;

   // s_ready stays low through reset and comes up after the first enabled edge.
   assign s.s_ready   = ready_en_q && (state_q != WAIT_COMMIT);
   assign accept      = s.s_valid && s.s_ready && clk_enable;
   assign is_final    = (cnt_q == CNT_BITS'(DATA_BYTES - 1));
   assign in_coeffs   = (cnt_q < CNT_BITS'(COEFF_BYTES));
   assign commit_done = commit;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         idx_q      <= '0;
         shadow_q   <= '0;
         ready_en_q <= 1'b0;
      end else if (clk_enable) begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shadow_q   <= shadow_d;
         ready_en_q <= 1'b1;
      end
   end

`ifdef EQ_COEFF_LOADER_CHECKSUM_EN
   logic [7:0] csum_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         csum_q <= '0;
      end else if (accept) begin
         if (state_q == IDLE) begin
            csum_q <= s.s_data;
         end else if ((state_q == HDR_OK || state_q == LOAD) && in_coeffs) begin
            csum_q <= csum_q ^ s.s_data;
         end
      end
   end

   assign csum_ok = (csum_q == s.s_data);
`else
   assign csum_ok = 1'b1;
`endif

   // Bytes shift in MSB-first, so tap 0 ends up in the top slice of the shadow.
   always_comb begin
      commit_data = '0;
      for (int t = 0; t < NUMBER_OF_TAPS; t++) begin
         commit_data[t*COEFF_BITS +: COEFF_BITS] =
            shadow_q[(NUMBER_OF_TAPS-1-t)*COEFF_BITS +: COEFF_BITS];
      end
   end

   // NOTE: every output of this block gets a default first, so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shadow_d    = shadow_q;
      commit      = 1'b0;
      frame_error = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               idx_d = s.s_data[HDR_IDX_BITS-1:0];
               cnt_d = '0;
               if (s.s_last) begin
                  frame_error = 1'b1;
               end else if (int'(s.s_data[HDR_IDX_BITS-1:0]) >= NUMBER_OF_FILTERS) begin
                  state_d = DRAIN;
               end else begin
                  state_d = HDR_OK;
               end
            end
         end
         HDR_OK, LOAD: begin
            if (accept) begin
               if (in_coeffs) begin
                  shadow_d = {shadow_q[SHADOW_BITS-9:0], s.s_data};
               end
               // An early s_last already closes the frame, so reject it on the spot.
               if (s.s_last && !is_final) begin
                  frame_error = 1'b1;
                  state_d     = IDLE;
               end else if (is_final && !s.s_last) begin
                  state_d = DRAIN;
               end else if (is_final) begin
                  if (csum_ok) begin
                     state_d = WAIT_COMMIT;
                  end else begin
                     frame_error = 1'b1;
                     state_d     = IDLE;
                  end
               end else begin
                  state_d = LOAD;
                  cnt_d   = cnt_q + CNT_BITS'(1);
               end
            end
         end
         WAIT_COMMIT: begin
            if (clk_enable && phase_min) begin
               commit  = 1'b1;
               state_d = IDLE;
            end
         end
         DRAIN: begin
            if (accept && s.s_last) begin
               frame_error = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   eq_coeff_bank #(
      .NUMBER_OF_FILTERS (NUMBER_OF_FILTERS),
      .NUMBER_OF_TAPS    (NUMBER_OF_TAPS),
      .COEFF_BITS        (COEFF_BITS)
   ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .commit      (commit),
      .commit_idx  (idx_q),
      .commit_data (commit_data),
      .coeffs_feed (coeffs_feed)
   );

endmodule
